spi_sample_shifter: RTL and testbench
=====================================

Name: spi_sample_shifter

Overview:
SPI slave serializer that sits directly downstream of the two's-complement sample stage. It accepts the complemented N-bit sample word over a valid/ready handshake and holds it in a one-entry buffer. It then shifts the word out on MISO to the external Arduino SPI master (mode 0, MSB first) while capturing the master's MOSI word. All SPI inputs are asynchronous to clk and are oversampled.

Parameters:
N, 8, word width in bits (tx and rx); N >= 2
SYNC_STAGES, 2, flip-flop depth of each SPI input synchronizer; >= 2

Ports:
clk  in  1  system clock; must be >= 2*(SYNC_STAGES+2) times spi_sclk frequency
rst_n  in  1  asynchronous, active-low reset
tx_data  in  N  complemented sample word from the complementer stage
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready at a rising clk edge
rx_data  out  N  last complete MOSI word; stable until the next rx_valid
rx_valid  out  1  one-cycle pulse when rx_data updates
spi_sclk  in  1  SPI clock from master (CPOL=0)
spi_cs_n  in  1  SPI chip select, active low
spi_mosi  in  1  master out
spi_miso  out  1  slave out; 0 when deselected
spi_miso_oe  out  1  1 while the synchronized cs_n is low (pad tristate control)
underrun  out  1  one-cycle pulse when a word starts with the holding register empty
frame_err  out  1  one-cycle pulse when cs_n deasserts with 0 < bit_cnt < N

Behaviour:
- Reset (async assert, sync release): holding and shift registers 0, pending=0, so tx_ready=1. rx_data=0, rx_valid=0, underrun=0, frame_err=0, spi_miso=0, spi_miso_oe=0. State=IDLE, bit_cnt=0. Synchronizer reset values: sclk 0, cs_n 1, mosi 0.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. One extra flop on sclk and cs_n gives rise and fall detection. All events below refer to these synchronized edges.
- Handshake: tx_ready = ~pending (registered). Accepting a word sets pending and stores tx_data. A load into the shift register clears pending. If the load and an accept happen in the same cycle, pending stays 1 and takes the new word.
- States:
  - IDLE -> LOAD on cs_n fall.
  - LOAD (1 cycle): shift_reg <= pending ? hold : 0, clear pending. If pending was 0, pulse underrun. bit_cnt=0. Go to SHIFT.
  - SHIFT:
    - sclk rise: rx_sr <= {rx_sr[N-2:0], mosi}; bit_cnt++.
    - sclk fall with bit_cnt<N: shift_reg <<= 1.
    - Rise that makes bit_cnt==N: next cycle rx_data <= rx_sr, rx_valid pulse.
    - Next sclk fall after bit_cnt==N: go to LOAD, so back-to-back words within one cs frame are supported.
  - Any state, cs_n rise: go to IDLE, bit_cnt=0, partial rx discarded (no rx_valid). frame_err pulses iff 0<bit_cnt<N. A shift_reg already loaded for a word that never started is lost; pending is untouched.
- spi_miso = spi_miso_oe ? shift_reg[N-1] : 0.
- Latency: raw cs_n fall to first MSB on MISO is SYNC_STAGES+2 clk cycles. The clk ratio above guarantees this lands before the first sclk rise.
- sclk edges seen in IDLE are ignored. cs_n rise and sclk edge in the same cycle: cs_n wins.
- rx_valid and frame_err are mutually exclusive by construction.

Decomposition:
- Package mini_spi_pkg holds:
  - state enum (IDLE, LOAD, SHIFT)
  - constants CPOL=0, CPHA=0
  - function clog2 used to size bit_cnt as clog2(N+1) bits
- One sub-module, spi_sync: parameterized SYNC_STAGES-flop synchronizer with a RESET_VAL parameter, instantiated three times.
- Edge detection, FSM and datapath stay in the top module.

Test Plan:
- Reset mid-frame: assert rst_n=0 during SHIFT with bit_cnt=3 -> all outputs at reset values immediately. After release, tx_ready=1 and state IDLE.
- Single word: accept tx_data=8'hF3 (two's complement of 8'h0D), master sends MOSI 8'hA5 in mode 0 at clk/16 -> master reads 8'hF3 on MISO. rx_data=8'hA5 with one rx_valid pulse. tx_ready back to 1 one cycle after LOAD.
- Back-to-back: preload 8'h01, then 8'hFF accepted during word 1, 16 sclk cycles in one cs frame -> MISO 8'h01 then 8'hFF. Two rx_valid pulses, underrun never asserted.
- Underrun: cs_n falls with tx_ready=1 (no data) -> underrun pulse one cycle after LOAD, MISO reads 8'h00, rx still captured.
- Abort: cs_n rises after 5 sclk rises -> frame_err single pulse, no rx_valid, rx_data unchanged. Next frame with 8'h3C pending shifts 8'h3C cleanly.
- Stray clocks: 4 sclk pulses with cs_n high -> no state change, spi_miso=0, spi_miso_oe=0, tx_ready unchanged.

Source files
------------

// File: rtl/spi_sample_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mini_spi_pkg
//  Purpose  : Shared types and helpers for the SPI sample shifter slice.
//             - state_e : serializer state encoding
//             - CPOL/CPHA : SPI mode implemented (mode 0)
//             - clog2 : constant-evaluable ceil(log2()) used to size counters
//  Revision : 1.0  initial release
// ============================================================================
package mini_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sample_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sample_shifter_if
//  Purpose  : Bundles the sample-word handshake, received-word output, SPI
//             pins and status pulses of the SPI sample shifter.
//  Ports    : tx_data/tx_valid/tx_ready  - sample word in (valid/ready)
//             rx_data/rx_valid           - captured MOSI word out
//             spi_sclk/spi_cs_n/spi_mosi - pins from the SPI master
//             spi_miso/spi_miso_oe       - slave output pin and pad enable
//             underrun/frame_err         - one-cycle status pulses
//  Modports : slave  - the shifter's view
//             master - the environment's view (upstream stage + SPI master)
//  Revision : 1.0  initial release
// ============================================================================
interface spi_sample_shifter_if #(
  parameter int N = 8
) ();

  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         spi_sclk;
  logic         spi_cs_n;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic         underrun;
  logic         frame_err;

  modport slave (
    input  tx_data, tx_valid, spi_sclk, spi_cs_n, spi_mosi,
    output tx_ready, rx_data, rx_valid, spi_miso, spi_miso_oe,
           underrun, frame_err
  );

  modport master (
    output tx_data, tx_valid, spi_sclk, spi_cs_n, spi_mosi,
    input  tx_ready, rx_data, rx_valid, spi_miso, spi_miso_oe,
           underrun, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/spi_sample_shifter_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync
//  Purpose  : Multi-flop synchronizer for one asynchronous SPI pin.
//  Ports    : clk, rst_n - system clock, async active-low reset
//             i_d        - asynchronous input
//             o_q        - synchronized output (SYNC_STAGES clk latency)
//  Params   : SYNC_STAGES - chain depth (>= 2)
//             RESET_VAL   - value held by every stage during reset, chosen
//                           as the pin's idle level so no false edge appears
//                           on reset release
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_sample_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sample_shifter
//  Purpose  : SPI mode-0 slave serializer. Buffers one complemented sample
//             word from the upstream stage and shifts it out MSB first on
//             MISO while capturing the master's MOSI word. SPI pins are
//             oversampled by clk.
//  Ports    : clk   - system clock (>= 2*(SYNC_STAGES+2) x sclk)
//             rst_n - asynchronous active-low reset
//             bus   - spi_sample_shifter_if.slave: tx handshake, rx word,
//                     SPI pins, underrun / frame_err pulses
//  Params   : N           - word width (>= 2)
//             SYNC_STAGES - synchronizer depth per SPI input (>= 2)
//  Revision : 1.0  initial release
// ============================================================================
module spi_sample_shifter
  import mini_spi_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  spi_sample_shifter_if.slave  bus
);

  localparam int             CNT_W   = clog2(N + 1);
  localparam logic [CNT_W-1:0] C_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_N_M1 = CNT_W'(N - 1);

  // ---------------------------------------------------------------- sync
  logic w_sclk_s;
  logic w_cs_n_s;
  logic w_mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(bus.spi_sclk), .o_q(w_sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .i_d(bus.spi_cs_n), .o_q(w_cs_n_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(bus.spi_mosi), .o_q(w_mosi_s)
  );

  // -------------------------------------------------------- edge detect
  logic r_sclk_d;
  logic r_cs_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_cs_n_d <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_n_d <= w_cs_n_s;
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_rise   =  w_cs_n_s & ~r_cs_n_d;
  assign w_cs_fall   = ~w_cs_n_s &  r_cs_n_d;

  // ---------------------------------------------------------------- FSM
  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_do_load;
  logic             w_do_rx;
  logic             w_do_tx_shift;
  logic             w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Deselect overrides everything, including a simultaneous sclk edge.
  always_comb begin
    w_next_state  = r_state;
    w_do_load     = 1'b0;
    w_do_rx       = 1'b0;
    w_do_tx_shift = 1'b0;
    w_abort       = 1'b0;
    if (w_cs_rise) begin
      w_next_state = IDLE;
      w_abort      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            w_next_state = LOAD;
          end
        end
        LOAD: begin
          w_do_load    = 1'b1;
          w_next_state = SHIFT;
        end
        SHIFT: begin
          // A rise after the word is complete cannot occur in mode 0;
          // guarding it keeps bit_cnt from wrapping.
          if (w_sclk_rise && (r_bit_cnt != C_N)) begin
            w_do_rx = 1'b1;
          end else if (w_sclk_fall) begin
            if (r_bit_cnt == C_N) begin
              w_next_state = LOAD;
            end else begin
              w_do_tx_shift = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  logic [N-1:0] r_hold;
  logic         r_pending;
  logic [N-1:0] r_shift;
  logic [N-1:0] r_rx_sr;
  logic [N-1:0] r_rx_data;
  logic         r_rx_valid;
  logic         r_word_done;
  logic         r_underrun;
  logic         r_frame_err;
  logic         w_accept;

  // tx_ready is ~pending, so an accept can only coincide with a load whose
  // buffer is empty; the new word then stays pending for the next load.
  assign w_accept = bus.tx_valid & ~r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_hold    <= bus.tx_data;
      r_pending <= 1'b1;
    end else if (w_do_load) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_rx_sr     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_word_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_word_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_abort) begin
        r_bit_cnt   <= '0;
        r_frame_err <= (r_bit_cnt != '0) && (r_bit_cnt < C_N);
      end

      if (w_do_load) begin
        r_shift    <= r_pending ? r_hold : '0;
        r_underrun <= ~r_pending;
        r_bit_cnt  <= '0;
      end

      if (w_do_rx) begin
        r_rx_sr     <= {r_rx_sr[N-2:0], w_mosi_s};
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        r_word_done <= (r_bit_cnt == C_N_M1);
      end

      if (w_do_tx_shift) begin
        r_shift <= {r_shift[N-2:0], 1'b0};
      end

      // Publish one cycle after the completing rise; a complete word is
      // delivered even if the master deselects in that cycle.
      if (r_word_done) begin
        r_rx_data  <= r_rx_sr;
        r_rx_valid <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.tx_ready    = ~r_pending;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.underrun    = r_underrun;
  assign bus.frame_err   = r_frame_err;
  assign bus.spi_miso_oe = ~w_cs_n_s;
  assign bus.spi_miso    = (~w_cs_n_s) ? r_shift[N-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_sample_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_sample_shifter
//  Purpose  : Directed self-checking bench for spi_sample_shifter (N=8,
//             SYNC_STAGES=2, sclk = clk/16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_sample_shifter;
  import mini_spi_pkg::*;

  logic clk;
  logic rst_n;

  spi_sample_shifter_if #(.N(8)) u_if ();

  spi_sample_shifter #(.N(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters sampled away from the active edge.
  int n_rxv  = 0;
  int n_und  = 0;
  int n_ferr = 0;

  always @(negedge clk) begin
    if (u_if.rx_valid  === 1'b1) n_rxv++;
    if (u_if.underrun  === 1'b1) n_und++;
    if (u_if.frame_err === 1'b1) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    @(negedge clk);
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
  endtask

  // Mode-0 master: MOSI set while sclk low, MISO sampled at the raw rise.
  // With end_frame the chip select rises together with the final fall.
  task automatic spi_bits(input logic [7:0] mosi_w, input int nbits,
                          input bit end_frame, output logic [7:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      u_if.spi_mosi = mosi_w[7-i];
      repeat (8) @(negedge clk);
      u_if.spi_sclk = 1'b1;
      miso_w[7-i] = u_if.spi_miso;
      repeat (8) @(negedge clk);
      u_if.spi_sclk = 1'b0;
      if (end_frame && (i == nbits - 1)) u_if.spi_cs_n = 1'b1;
    end
    if (end_frame) repeat (8) @(negedge clk);
  endtask

  task automatic frame_start();
    u_if.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] miso_w;
  int rxv0, und0, ferr0;

  initial begin
    rst_n         = 1'b0;
    u_if.tx_data  = '0;
    u_if.tx_valid = 1'b0;
    u_if.spi_sclk = 1'b0;
    u_if.spi_cs_n = 1'b1;
    u_if.spi_mosi = 1'b0;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(u_if.tx_ready), 32'd1);
    check("rst_rx_data",  32'(u_if.rx_data), 32'h00);
    check("rst_rx_valid", 32'(u_if.rx_valid), 32'd0);
    check("rst_miso",     32'(u_if.spi_miso), 32'd0);
    check("rst_miso_oe",  32'(u_if.spi_miso_oe), 32'd0);
    check("rst_underrun", 32'(u_if.underrun), 32'd0);
    check("rst_frame_err", 32'(u_if.frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- single word, latency and tx_ready timing
    push_word(8'hF3);
    check("single_tx_ready_busy", 32'(u_if.tx_ready), 32'd0);
    rxv0 = n_rxv; und0 = n_und;
    u_if.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    check("single_miso_before_load", 32'(u_if.spi_miso), 32'd0);
    check("single_oe_on", 32'(u_if.spi_miso_oe), 32'd1);
    check("single_tx_ready_in_load", 32'(u_if.tx_ready), 32'd0);
    @(negedge clk);
    check("single_miso_msb_latency", 32'(u_if.spi_miso), 32'd1);
    check("single_tx_ready_after_load", 32'(u_if.tx_ready), 32'd1);
    repeat (4) @(negedge clk);
    spi_bits(8'hA5, 8, 1'b1, miso_w);
    check("single_miso_word", 32'(miso_w), 32'hF3);
    check("single_rx_data", 32'(u_if.rx_data), 32'hA5);
    check("single_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);
    check("single_no_underrun", 32'(n_und - und0), 32'd0);
    check("single_oe_off", 32'(u_if.spi_miso_oe), 32'd0);

    // ---------------- back-to-back words in one frame
    push_word(8'h01);
    rxv0 = n_rxv; und0 = n_und; ferr0 = n_ferr;
    frame_start();
    push_word(8'hFF);
    spi_bits(8'h96, 8, 1'b0, miso_w);
    check("b2b_miso_word1", 32'(miso_w), 32'h01);
    check("b2b_rx_data1", 32'(u_if.rx_data), 32'h96);
    spi_bits(8'h69, 8, 1'b1, miso_w);
    check("b2b_miso_word2", 32'(miso_w), 32'hFF);
    check("b2b_rx_data2", 32'(u_if.rx_data), 32'h69);
    check("b2b_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd2);
    check("b2b_no_underrun", 32'(n_und - und0), 32'd0);
    check("b2b_no_frame_err", 32'(n_ferr - ferr0), 32'd0);
    check("b2b_tx_ready", 32'(u_if.tx_ready), 32'd1);

    // ---------------- underrun
    rxv0 = n_rxv; und0 = n_und;
    u_if.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check("under_pulse_high", 32'(u_if.underrun), 32'd1);
    @(negedge clk);
    check("under_pulse_low", 32'(u_if.underrun), 32'd0);
    repeat (3) @(negedge clk);
    spi_bits(8'hC3, 8, 1'b1, miso_w);
    check("under_miso_zero", 32'(miso_w), 32'h00);
    check("under_rx_data", 32'(u_if.rx_data), 32'hC3);
    check("under_rx_valid_pulses", 32'(n_rxv - rxv0), 32'd1);
    check("under_pulse_count", 32'(n_und - und0), 32'd1);

    // ---------------- abort after 5 bits
    rxv0 = n_rxv; ferr0 = n_ferr;
    frame_start();
    spi_bits(8'hE7, 5, 1'b1, miso_w);
    check("abort_frame_err_count", 32'(n_ferr - ferr0), 32'd1);
    check("abort_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
    check("abort_rx_data_kept", 32'(u_if.rx_data), 32'hC3);
    push_word(8'h3C);
    rxv0 = n_rxv; ferr0 = n_ferr;
    frame_start();
    spi_bits(8'h11, 8, 1'b1, miso_w);
    check("after_abort_miso", 32'(miso_w), 32'h3C);
    check("after_abort_rx_data", 32'(u_if.rx_data), 32'h11);
    check("after_abort_rx_valid", 32'(n_rxv - rxv0), 32'd1);
    check("after_abort_no_ferr", 32'(n_ferr - ferr0), 32'd0);

    // ---------------- stray sclk with cs_n high
    push_word(8'h77);
    rxv0 = n_rxv; und0 = n_und; ferr0 = n_ferr;
    for (int k = 0; k < 4; k++) begin
      u_if.spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      check("stray_miso", 32'(u_if.spi_miso), 32'd0);
      check("stray_oe", 32'(u_if.spi_miso_oe), 32'd0);
      u_if.spi_sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("stray_tx_ready_held", 32'(u_if.tx_ready), 32'd0);
    check("stray_state_idle", 32'(dut.r_state), 32'(IDLE));
    check("stray_no_pulses", 32'((n_rxv - rxv0) + (n_und - und0) + (n_ferr - ferr0)), 32'd0);

    // ---------------- reset in the middle of a word
    frame_start();
    spi_bits(8'hAA, 3, 1'b0, miso_w);
    repeat (4) @(negedge clk);
    check("midrst_state_shift", 32'(dut.r_state), 32'(SHIFT));
    check("midrst_bit_cnt", 32'(dut.r_bit_cnt), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_ready", 32'(u_if.tx_ready), 32'd1);
    check("midrst_rx_data", 32'(u_if.rx_data), 32'h00);
    check("midrst_miso", 32'(u_if.spi_miso), 32'd0);
    check("midrst_oe", 32'(u_if.spi_miso_oe), 32'd0);
    check("midrst_flags", 32'({u_if.rx_valid, u_if.underrun, u_if.frame_err}), 32'd0);
    u_if.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    ferr0 = n_ferr;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postrst_tx_ready", 32'(u_if.tx_ready), 32'd1);
    check("postrst_state_idle", 32'(dut.r_state), 32'(IDLE));
    check("postrst_no_frame_err", 32'(n_ferr - ferr0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
